// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit direction counter + target per entry, resolved and trained from EX.
// Define BP_PERF_EN to build the resolved-branch / mispredict performance counters.
module branch_predictor #(
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_cmp_result,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    cnt_e             cnt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic             train;
    logic             mispredict;
    logic [31:0]      ex_next;
    logic [31:0]      tgt_d;
    cnt_e             cnt_d;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign train  = rstn && ex_valid && !ex_stall;

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = if_pc + 32'd4;
        if (rstn && if_hit && (cnt_q[if_idx] inside {WT, ST})) begin
            pred_taken  = 1'b1;
            pred_target = tgt_q[if_idx];
        end
    end

    always_comb begin
        ex_next     = ex_cmp_result ? ex_target : ex_pc + 32'd4;
        mispredict  = ex_valid && ((ex_cmp_result != ex_pred_taken) || (ex_next != ex_pred_target));
        redirect    = rstn && mispredict;
        redirect_pc = (rstn && ex_valid) ? ex_next : '0;
    end

    // A miss allocates fresh: counter starts weak in the resolved direction.
    always_comb begin
        cnt_d = ex_cmp_result ? WT : WNT;
        tgt_d = ex_target;
        if (ex_hit) begin
            if (!ex_cmp_result) begin
                tgt_d = tgt_q[ex_idx];
            end
            case (cnt_q[ex_idx])
                SNT: cnt_d = ex_cmp_result ? WNT : SNT;
                WNT: cnt_d = ex_cmp_result ? WT  : SNT;
                WT:  cnt_d = ex_cmp_result ? ST  : WNT;
                ST:  cnt_d = ex_cmp_result ? ST  : WT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '{default: 1'b0};
            tag_q   <= '{default: '0};
            tgt_q   <= '{default: '0};
            cnt_q   <= '{default: cnt_e'(CNT_INIT)};
        end else if (train) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            tgt_q[ex_idx]   <= tgt_d;
            cnt_q[ex_idx]   <= cnt_d;
        end
    end

`ifdef BP_PERF_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_br_d;
    logic [31:0] perf_mp_q;
    logic [31:0] perf_mp_d;

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (train) begin
            if (perf_br_q != '1) begin
                perf_br_d = perf_br_q + 32'd1;
            end
            if (mispredict && (perf_mp_q != '1)) begin
                perf_mp_d = perf_mp_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed literal checks plus randomized traffic vs. a table model.
`timescale 1ns/1ps
module tb_branch_predictor;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned N     = 16;
`ifdef BP_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_cmp_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
        .clk(clk), .rstn(rstn), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_cmp_result(ex_cmp_result), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    // Reference model: plain arrays, counter kept as an integer 0..3.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    logic [31:0] m_br = '0;
    logic [31:0] m_mp = '0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % N;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_next();
        return ex_cmp_result ? ex_target : ex_pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return ex_valid && ((ex_cmp_result != ex_pred_taken) || (m_next() != ex_pred_target));
    endfunction

    function automatic int sat_step(input int c, input bit up);
        if (up) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= 0;
                m_tgt[i]   <= '0;
                m_cnt[i]   <= 1;
            end
            m_br <= '0;
            m_mp <= '0;
        end else if (ex_valid && !ex_stall) begin
            m_br <= (m_br == 32'hFFFF_FFFF) ? m_br : m_br + 32'd1;
            if (m_mispredict()) m_mp <= (m_mp == 32'hFFFF_FFFF) ? m_mp : m_mp + 32'd1;
            m_valid[idx_of(ex_pc)] <= 1'b1;
            m_tag[idx_of(ex_pc)]   <= tag_of(ex_pc);
            if (m_hit(ex_pc)) begin
                m_cnt[idx_of(ex_pc)] <= sat_step(m_cnt[idx_of(ex_pc)], ex_cmp_result);
                if (ex_cmp_result) m_tgt[idx_of(ex_pc)] <= ex_target;
            end else begin
                m_cnt[idx_of(ex_pc)] <= ex_cmp_result ? 2 : 1;
                m_tgt[idx_of(ex_pc)] <= ex_target;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_pred_taken", {31'b0, pred_taken}, {31'b0, rstn ? m_pred_taken(if_pc) : 1'b0});
        chk("m_pred_target", pred_target, rstn ? m_pred_target(if_pc) : if_pc + 32'd4);
        chk("m_redirect", {31'b0, redirect}, {31'b0, rstn && m_mispredict()});
        chk("m_redirect_pc", redirect_pc, (rstn && ex_valid) ? m_next() : 32'd0);
        chk("m_perf_br", perf_branches, PERF ? m_br : 32'd0);
        chk("m_perf_mp", perf_mispredicts, PERF ? m_mp : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_ex(input logic v, input logic s, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic cmp, input logic pt, input logic [31:0] ptg);
        ex_valid = v; ex_stall = s; ex_pc = pc; ex_target = tgt;
        ex_cmp_result = cmp; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk_pred(input string name, input logic t, input logic [31:0] tgt);
        chk({name, "_taken"}, {31'b0, pred_taken}, {31'b0, t});
        chk({name, "_target"}, pred_target, tgt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] rtg;
        rstn = 1'b0; if_pc = 32'h100; idle();
        step();
        settle();
        chk_pred("rst", 1'b0, 32'h104);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_perf_br", perf_branches, 32'd0);
        chk("rst_perf_mp", perf_mispredicts, 32'd0);
        set_ex(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
        settle();
        chk("rst_ex_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_ex_redirect_pc", redirect_pc, 32'd0);
        step();
        rstn = 1'b1; idle();
        settle();
        chk_pred("rst_no_train", 1'b0, 32'h104);
        step();

        set_ex(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
        settle();
        chk("train_redirect", {31'b0, redirect}, 32'd1);
        chk("train_redirect_pc", redirect_pc, 32'h80);
        chk_pred("same_cycle_old", 1'b0, 32'h104);
        step();
        idle();
        settle();
        chk_pred("after_train", 1'b1, 32'h80);
        step();
        repeat (3) begin
            set_ex(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
            settle();
            chk("correct_no_redirect", {31'b0, redirect}, 32'd0);
            step();
        end
        set_ex(1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
        settle();
        chk("nt_redirect", {31'b0, redirect}, 32'd1);
        chk("nt_redirect_pc", redirect_pc, 32'h104);
        step();
        idle();
        settle();
        chk_pred("sat_then_down", 1'b1, 32'h80);
        set_ex(1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
        step();
        idle();
        settle();
        chk_pred("down_to_wnt", 1'b0, 32'h104);

        set_ex(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h104);
        step();
        set_ex(1'b1, 1'b0, 32'h140, 32'h400, 1'b0, 1'b0, 32'h144);
        step();
        idle(); if_pc = 32'h100;
        settle();
        chk_pred("alias_evicted", 1'b0, 32'h104);
        if_pc = 32'h140;
        settle();
        chk_pred("alias_new", 1'b0, 32'h144);
        step();

        rstn = 1'b0;
        step();
        rstn = 1'b1; if_pc = 32'h200;
        set_ex(1'b1, 1'b1, 32'h200, 32'h300, 1'b1, 1'b0, 32'h204);
        repeat (3) begin
            settle();
            chk("stall_redirect", {31'b0, redirect}, 32'd1);
            step();
        end
        ex_stall = 1'b0;
        settle();
        chk("stall_perf_br_pre", perf_branches, 32'd0);
        step();
        idle();
        settle();
        chk_pred("stall_once", 1'b1, 32'h300);
        chk("stall_perf_br", perf_branches, PERF ? 32'd1 : 32'd0);
        chk("stall_perf_mp", perf_mispredicts, PERF ? 32'd1 : 32'd0);
        set_ex(1'b1, 1'b0, 32'h200, 32'h300, 1'b0, 1'b1, 32'h300);
        step();
        idle();
        settle();
        chk_pred("stall_single_step", 1'b0, 32'h204);

        rstn = 1'b0;
        set_ex(1'b1, 1'b0, 32'h300, 32'h500, 1'b1, 1'b0, 32'h304);
        step();
        rstn = 1'b1; idle(); if_pc = 32'h300;
        settle();
        chk_pred("rst_pulse", 1'b0, 32'h304);
        chk("rst_pulse_perf_br", perf_branches, 32'd0);
        chk("rst_pulse_perf_mp", perf_mispredicts, 32'd0);
        if_pc = 32'hFFFF_FFFC;
        settle();
        chk_pred("wrap", 1'b0, 32'h0);
        step();

        for (int k = 0; k < 3000; k++) begin
            rstn  = ($urandom_range(0, 99) != 0);
            if_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rpc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rtg   = $urandom & 32'h0000_0FFC;
            set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rpc, rtg,
                   1'($urandom_range(0, 1)), 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = m_pred_taken(rpc);
                ex_pred_target = m_pred_target(rpc);
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       ex_pred_target = rtg;
                    1:       ex_pred_target = rpc + 32'd4;
                    default: ex_pred_target = $urandom;
                endcase
            end
            step();
        end
        idle();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch direction and target predictor for the pipelined RV32 core.
- Sits between IF and EX. IF asks it for a prediction for the fetch PC.
- In EX it consumes the branch-comparator result (taken/not-taken, one bit), detects mispredictions, issues the PC redirect and trains its tables.
- It is the consumer end of the comparator's branch decision: IF predicts ahead, EX resolves.

Parameters:
- IDX_W, 4, index width; table has 2^IDX_W entries (default 16).
- CNT_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset
- if_pc  in  32  fetch PC to predict
- pred_taken  out  1  prediction for if_pc
- pred_target  out  32  predicted next PC for if_pc
- ex_valid  in  1  EX stage holds a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- ex_stall  in  1  EX stage stalled this cycle
- ex_pc  in  32  PC of the branch in EX
- ex_target  in  32  computed branch target (pc+imm)
- ex_cmp_result  in  1  comparator output: 1 = taken
- ex_pred_taken  in  1  prediction carried down the pipeline for this branch
- ex_pred_target  in  32  predicted next PC carried down the pipeline
- redirect  out  1  mispredict: flush IF/ID, load redirect_pc
- redirect_pc  out  32  correct next PC
- perf_branches  out  32  resolved-branch count (optional feature)
- perf_mispredicts  out  32  mispredict count (optional feature)

Behaviour:
- Storage per entry: valid (1), tag (32-IDX_W-2 bits), target (32), counter (2). Register array, not RAM.
- Address split: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Reset (rstn=0 at a clock edge):
  - all valid bits clear; counters = CNT_INIT; tags and targets = 0; perf counters = 0.
  - Reset mid-training discards that update.
  - While rstn=0, pred_taken=0, pred_target=if_pc+4, redirect=0, redirect_pc=0.
- Predict (combinational, 0-cycle):
  - hit = valid[idx] & (tag[idx]==tag(if_pc)).
  - pred_taken = hit & counter[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- Resolve (combinational from EX inputs):
  - next = ex_cmp_result ? ex_target : ex_pc+4.
  - redirect = ex_valid & (ex_cmp_result != ex_pred_taken | next != ex_pred_target).
  - redirect_pc = next when ex_valid, else 0.
  - redirect is asserted regardless of ex_stall; the pipeline owns flush timing.
- Train (registered): update fires when ex_valid & ~ex_stall & rstn. A stalled branch trains exactly once, on its unstalled cycle.
  - On hit at ex_pc:
    - counter saturating: taken -> min(c+1,3); not taken -> max(c-1,0).
    - target <= ex_target when taken.
  - On miss: allocate/replace (direct-mapped). valid=1, tag written, target=ex_target, counter = taken ? 2'b10 : 2'b01.
- Same-cycle read/write to one index: the IF read sees the old contents. No bypass; the new value is visible next cycle.
- Counter state machine per entry: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).
  - taken steps right, not-taken steps left.
  - Saturates at the ends; no wrap from 11 to 00.

Optional Feature:
- Macro BP_PERF_EN.
- Defined:
  - perf_branches increments on every train event.
  - perf_mispredicts increments on train events where redirect=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: counter logic is not built; both ports are driven constant 0. The port list is unchanged.

Test Plan:
- Reset, if_pc=0x00000100 -> pred_taken=0, pred_target=0x00000104, redirect=0. Counters at 0 with BP_PERF_EN.
- Train ex_pc=0x100, ex_target=0x80, cmp=1, pred 0/0x104 -> redirect=1, redirect_pc=0x80. Next cycle if_pc=0x100 gives pred_taken=1 (counter 10), pred_target=0x80.
- Resolve the same branch taken 3 more times, then not-taken once -> counter saturates at 11 then drops to 10; prediction stays taken with target 0x80. The not-taken resolve with pred 1/0x80 gives redirect_pc=0x104.
- Alias: train 0x100 taken, then train 0x140 (same idx with IDX_W=4, different tag) not-taken -> if_pc=0x100 misses: pred_taken=0, pred_target=0x104.
- ex_valid=1, ex_stall=1 for 3 cycles then 0, cmp=1 -> exactly one counter step. With BP_PERF_EN, perf_branches=1.
- Pulse rstn=0 in the same cycle as a train event -> no update; entry invalid; perf counters 0.
